// File: rtl/pingpong_pkg.sv
// Shared constants for the pingpong paddle input path: the switch channel map
// and the per-channel auto-repeat state encoding.
package pingpong_pkg;

  localparam int SW_A_UP = 0;
  localparam int SW_A_DN = 1;
  localparam int SW_B_UP = 2;
  localparam int SW_B_DN = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } ch_state_e;

endpackage

// File: rtl/pingpong_sw_channel.sv
// One paddle switch: 2-flop synchroniser, debounce and the press/auto-repeat FSM.
// The move pulse leaves this block unregistered; the top masks and registers it.
module pingpong_sw_channel
  import pingpong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 8,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic stable,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  ch_state_e        state_q, state_d;
  logic             pulse_d;

  always_comb begin
    sync1_d   = sw_raw;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d  = sync2_q;
        deb_cnt_d = '0;
      end else if (deb_cnt_q != CNT_MAX) begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q;
      end
    end
  end

  // A release observed in any state aborts straight back to IDLE without a pulse.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    pulse_d   = 1'b0;
    if (!stable_q) begin
      state_d   = IDLE;
      rep_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pulse_d   = 1'b1;
          state_d   = DELAY;
          rep_cnt_d = '0;
        end
        DELAY: begin
          if (rep_cnt_q == DELAY_LAST) begin
            pulse_d   = 1'b1;
            state_d   = REPEAT;
            rep_cnt_d = '0;
          end else if (rep_cnt_q != CNT_MAX) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rep_cnt_q == RATE_LAST) begin
            pulse_d   = 1'b1;
            rep_cnt_d = '0;
          end else if (rep_cnt_q != CNT_MAX) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
      rep_cnt_q <= '0;
      state_q   <= IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      state_q   <= state_d;
    end
  end

  assign stable = stable_q;
  assign pulse  = pulse_d;

endmodule

// File: rtl/pingpong_paddle_input.sv
// Paddle switch conditioning: per-switch channels, then per-player up/down
// conflict masking and the registered one-cycle move pulses.
module pingpong_paddle_input
  import pingpong_pkg::*;
#(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 8,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] sw_stable,
  output logic              move_up_a,
  output logic              move_dn_a,
  output logic              move_up_b,
  output logic              move_dn_b
);

  logic [NUM_SW-1:0] stable_w;
  logic [NUM_SW-1:0] pulse_w;
  logic [NUM_SW-1:0] move_q, move_d;
  logic              conflict_a, conflict_b;

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_ch
    pingpong_sw_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sw_raw(sw[gi]),
      .stable(stable_w[gi]),
      .pulse (pulse_w[gi])
    );
  end

  // Both directions held by one player cancels that player's moves only;
  // the channel FSMs keep counting so repeats resume on the right beat.
  always_comb begin
    conflict_a      = stable_w[SW_A_UP] & stable_w[SW_A_DN];
    conflict_b      = stable_w[SW_B_UP] & stable_w[SW_B_DN];
    move_d          = '0;
    move_d[SW_A_UP] = pulse_w[SW_A_UP] & ~conflict_a;
    move_d[SW_A_DN] = pulse_w[SW_A_DN] & ~conflict_a;
    move_d[SW_B_UP] = pulse_w[SW_B_UP] & ~conflict_b;
    move_d[SW_B_DN] = pulse_w[SW_B_DN] & ~conflict_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_q <= '0;
    end else begin
      move_q <= move_d;
    end
  end

  assign sw_stable = stable_w;
  assign move_up_a = move_q[SW_A_UP];
  assign move_dn_a = move_q[SW_A_DN];
  assign move_up_b = move_q[SW_B_UP];
  assign move_dn_b = move_q[SW_B_DN];

endmodule

// File: tb/tb_pingpong_paddle_input.sv
// Bench for pingpong_paddle_input: directed segment table, reset sequences and
// randomized switch activity, all checked cycle by cycle against a history-based model.
module tb_pingpong_paddle_input;

  localparam int DEB  = 4;
  localparam int RD   = 8;
  localparam int RATE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] sw_stable;
  logic       move_up_a, move_dn_a, move_up_b, move_dn_b;

  always #5 clk = ~clk;

  pingpong_paddle_input #(
    .NUM_SW         (4),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RATE),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .sw_stable(sw_stable),
    .move_up_a(move_up_a),
    .move_dn_a(move_dn_a),
    .move_up_b(move_up_b),
    .move_dn_b(move_dn_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: raw switch samples feed a two-deep pipeline; a level is accepted once the
  // last DEB synced samples all disagree with it; held counts cycles at level 1.
  logic [3:0]     m_s1, m_s2, m_stab;
  logic [DEB-1:0] m_win [4];
  int             m_held [4];
  int             seg_cnt [4];

  typedef struct {
    logic [3:0] sw;
    int         cycles;
    int         c_up_a;
    int         c_dn_a;
    int         c_up_b;
    int         c_dn_b;
    logic [3:0] stab;
  } vec_t;

  vec_t vecs [13];

  task automatic model_reset();
    m_s1   = '0;
    m_s2   = '0;
    m_stab = '0;
    for (int i = 0; i < 4; i++) begin
      m_win[i]  = '0;
      m_held[i] = 0;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Starts and ends on a falling edge; applies v for exactly one rising edge.
  task automatic tick(input logic [3:0] v);
    logic [3:0] pre;
    logic [3:0] exp_mv;
    logic [7:0] got, want;
    sw = v;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      pre[i] = m_stab[i] && (m_held[i] == 1 ||
               (m_held[i] > RD && ((m_held[i] - RD - 1) % RATE) == 0));
    exp_mv[0] = pre[0] && !(m_stab[0] && m_stab[1]);
    exp_mv[1] = pre[1] && !(m_stab[0] && m_stab[1]);
    exp_mv[2] = pre[2] && !(m_stab[2] && m_stab[3]);
    exp_mv[3] = pre[3] && !(m_stab[2] && m_stab[3]);
    for (int i = 0; i < 4; i++) begin
      m_win[i] = {m_win[i][DEB-2:0], m_s2[i]};
      if (m_stab[i] ? (m_win[i] == '0) : (&m_win[i]))
        m_stab[i] = ~m_stab[i];
      if (m_stab[i]) m_held[i]++;
      else m_held[i] = 0;
    end
    m_s2 = m_s1;
    m_s1 = v;
    got  = {sw_stable, move_dn_b, move_up_b, move_dn_a, move_up_a};
    want = {m_stab, exp_mv};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL cycle %0d: got stable=%b moves=%b, expected stable=%b moves=%b",
               cyc, got[7:4], got[3:0], want[7:4], want[3:0]);
    end
    for (int i = 0; i < 4; i++) seg_cnt[i] += int'(got[i]);
    @(negedge clk);
  endtask

  initial begin
    int first_hit;
    logic [3:0] v;
    int hold;

    // sw, cycles, pulses up_a/dn_a/up_b/dn_b during the segment, sw_stable at its end
    vecs[0]  = '{4'b0001, 20, 4, 0, 0, 0, 4'b0001};
    vecs[1]  = '{4'b0000, 10, 3, 0, 0, 0, 4'b0000};
    vecs[2]  = '{4'b0100,  3, 0, 0, 0, 0, 4'b0000};
    vecs[3]  = '{4'b0000, 10, 0, 0, 0, 0, 4'b0000};
    vecs[4]  = '{4'b0100,  4, 0, 0, 0, 0, 4'b0000};
    vecs[5]  = '{4'b0000, 12, 0, 0, 1, 0, 4'b0000};
    vecs[6]  = '{4'b0011, 20, 0, 0, 0, 0, 4'b0011};
    vecs[7]  = '{4'b0001, 12, 3, 0, 0, 0, 4'b0001};
    vecs[8]  = '{4'b0000, 12, 3, 0, 0, 0, 4'b0000};
    vecs[9]  = '{4'b1001, 10, 1, 0, 0, 1, 4'b1001};
    vecs[10] = '{4'b0000, 10, 1, 0, 0, 1, 4'b0000};
    vecs[11] = '{4'b0010,  8, 0, 1, 0, 0, 4'b0010};
    vecs[12] = '{4'b0000, 12, 0, 0, 0, 0, 4'b0000};

    sw  = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", int'({sw_stable, move_dn_b, move_up_b, move_dn_a, move_up_a}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed segment table
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < 4; i++) seg_cnt[i] = 0;
      for (int c = 0; c < vecs[k].cycles; c++) tick(vecs[k].sw);
      check($sformatf("seg%0d_up_a", k), seg_cnt[0], vecs[k].c_up_a);
      check($sformatf("seg%0d_dn_a", k), seg_cnt[1], vecs[k].c_dn_a);
      check($sformatf("seg%0d_up_b", k), seg_cnt[2], vecs[k].c_up_b);
      check($sformatf("seg%0d_dn_b", k), seg_cnt[3], vecs[k].c_dn_b);
      check($sformatf("seg%0d_stable", k), int'(sw_stable), int'(vecs[k].stab));
      $display("seg %0d sw=%b cycles=%0d pulses=%0d/%0d/%0d/%0d stable=%b",
               k, vecs[k].sw, vecs[k].cycles, seg_cnt[0], seg_cnt[1], seg_cnt[2],
               seg_cnt[3], sw_stable);
    end

    // Reset mid-hold with every switch held: outputs clear without a clock edge
    for (int c = 0; c < 12; c++) tick(4'b1111);
    #2 rst = 1'b1;
    #1;
    check("rst_async_clear", int'({sw_stable, move_dn_b, move_up_b, move_dn_a, move_up_a}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick(4'b1111);
    check("rst_1111_stable", int'(sw_stable), 15);
    $display("reset with sw=1111: stable=%b", sw_stable);

    // Reset then release with a non-conflicting press: first pulses 7 edges later
    #2 rst = 1'b1;
    #1;
    check("rst2_async_clear", int'({sw_stable, move_dn_b, move_up_b, move_dn_a, move_up_a}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    first_hit = -1;
    for (int c = 1; c <= 10; c++) begin
      tick(4'b0101);
      if (first_hit < 0 && move_up_a && move_up_b) first_hit = c;
    end
    check("rst_release_latency", first_hit, DEB + 3);
    $display("reset release latency: %0d edges", first_hit);
    for (int c = 0; c < 20; c++) tick(4'b0000);

    // Randomized activity against the model
    v = '0;
    for (int s = 0; s < 250; s++) begin
      v    = v ^ 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(4, 24);
      for (int c = 0; c < hold; c++) tick(v);
    end
    for (int c = 0; c < 30; c++) tick(4'b0000);
    check("final_idle_stable", int'(sw_stable), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
